agc_level_ctrl: RTL and testbench
=================================

# agc_level_ctrl

Parametrised automatic-gain-control loop for the receive chain. It sits between the ADC sample stream and the VGA gain-select pins. Over fixed windows of valid samples it measures the clip count and the peak magnitude, then steps the VGA code up or down by one, with saturation. After each step it holds off for a programmable number of windows so the analog path can settle. Unlike the previous detector, it both raises and lowers gain, is windowed rather than run-length based, and is sized by parameters.

## Interface
- `DW`, 8: ADC sample width, offset-binary (midscale = 2^(DW-1)).
- `GW`, 3: VGA code width. A larger code means more attenuation (lower gain).
- `WIN_LEN`, 100: valid samples per measurement window, ≥ 2.
- `HI_THR`, 96: clip magnitude threshold (DW-1 bits).
- `LO_THR`, 24: low-signal peak threshold. Must satisfy LO_THR < HI_THR.
- `CLIP_CNT`, 8: clips per window needed to reduce gain, 1..WIN_LEN.
- `HOLD_WIN`, 2: windows ignored after a step (0 = no hold-off).
- `GAIN_INIT`, 3: VGA code at reset.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `digital_in` in DW: ADC sample.
- `sample_valid` in 1: qualifies `digital_in` this cycle.
- `agc_en` in 1: loop enable.
- `vga_control` out GW: VGA gain code, registered.
- `step_dn` out 1: one-cycle pulse when the code is incremented (gain reduced).
- `step_up` out 1: one-cycle pulse when the code is decremented (gain raised).
- `rail` out 1: one-cycle pulse when a step was wanted but the code is at 0 or 2^GW-1.

## Operation
- Magnitude: mag = x − mid if x ≥ mid, else mid − 1 − x. Width DW-1; the maximum is 2^(DW-1)−1 and the computation never overflows.
- A sample is a clip if mag ≥ HI_THR.
- Per window, the block keeps:
  - `win_cnt`, width clog2(WIN_LEN+1);
  - `clip_cnt`, saturating at CLIP_CNT;
  - `peak`, the running maximum of mag.
- FSM states: IDLE, MEASURE, DECIDE, HOLD.
  - IDLE: all counters and `peak` are 0. Go to MEASURE when `agc_en` = 1.
  - MEASURE: accumulate on each `sample_valid`. Go to DECIDE on the edge that accepts sample number WIN_LEN; that sample is included.
  - DECIDE: one cycle, and the sample input is ignored.
    - If clip_cnt ≥ CLIP_CNT: step down (code+1).
    - Else if peak < LO_THR: step up (code−1).
    - Else: no change.
    - A step that would leave the range 0..2^GW−1 is suppressed; `rail` pulses and the code holds.
    - If a step was taken and HOLD_WIN > 0, go to HOLD. Otherwise go to MEASURE.
    - Counters are cleared on exit from DECIDE.
  - HOLD: count HOLD_WIN × WIN_LEN valid samples without accumulating, then go to MEASURE with counters cleared.
- Clip takes priority over the low-signal rule. Because LO_THR < HI_THR, both conditions cannot hold together.
- `agc_en` = 0 in any state: go to IDLE on the next edge and clear the counters. `vga_control` holds its current value and no pulses are issued.
- Only the DECIDE path changes `vga_control`. It never wraps.

## Timing
- Reset values: `vga_control` = GAIN_INIT; `step_dn`, `step_up` and `rail` = 0; FSM = IDLE; all counters = 0.
- Reset takes effect immediately and asynchronously, including mid-window or mid-HOLD. On release, the first edge with `agc_en` = 1 moves IDLE to MEASURE.
- Latency: the edge accepting sample WIN_LEN gives state = DECIDE. The next edge updates `vga_control` and asserts the pulse for exactly one cycle, coincident with the new code.
- `sample_valid` may be asserted on any cycle, including back-to-back; gaps only stretch the window. A sample presented in the DECIDE cycle is dropped and is not counted toward the next window.

## Configuration
- `AGC_MANUAL_EN` defined:
  - Adds inputs `manual_en` (1 bit) and `manual_code` (GW bits).
  - While `manual_en` = 1: `vga_control` follows `manual_code` with one register stage, the FSM is forced to IDLE, and no pulses are issued.
  - On release, the loop resumes from the manual code.
- `AGC_MANUAL_EN` undefined: these ports and this logic are absent.

## Test plan
All scenarios use the default parameters.
- Reset: assert `rst_n` = 0 asynchronously between edges -> `vga_control` = 3 immediately; all pulses 0.
- Clipping: `agc_en` = 1 with continuous 0xFF (mag 127) -> `step_dn` after sample 100 and `vga_control` = 4. The next 200 samples cause no change. Then 5, 6, 7. Further windows -> `rail` pulses and the code stays 7.
- Silence: continuous 0x80 (mag 0) -> code 3→2→1→0, with each step separated by 300 samples. The next decision -> `rail` pulses and the code stays 0.
- Nominal: 0xA0 (mag 32) for 10 windows -> no pulses, code stays 3. Window with 7 samples of 0x00 (mag 127), rest 0xA0 -> no step. With 8 such samples -> `step_dn`.
- Mid-operation: drop `agc_en` at sample 50 -> counters cleared, code held. Re-enable -> a full 100-sample window is required before the next decision. Also check that a sample in the DECIDE cycle is not counted.
- `AGC_MANUAL_EN`: `manual_en` = 1 with `manual_code` = 6 -> `vga_control` = 6 one cycle later and no pulses. Release with 0x80 input -> code 5 after 100 samples.

Source files
------------

// File: rtl/agc_level_ctrl.sv
// rtl/agc_level_ctrl.sv - windowed clip/peak AGC loop stepping the VGA code up or down
// Optional feature macro: AGC_MANUAL_EN (manual VGA code override).
module agc_level_ctrl #(
  parameter int DW        = 8,
  parameter int GW        = 3,
  parameter int WIN_LEN   = 100,
  parameter int HI_THR    = 96,
  parameter int LO_THR    = 24,
  parameter int CLIP_CNT  = 8,
  parameter int HOLD_WIN  = 2,
  parameter int GAIN_INIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] digital_in,
  input  logic          sample_valid,
  input  logic          agc_en,
`ifdef AGC_MANUAL_EN
  input  logic          manual_en,
  input  logic [GW-1:0] manual_code,
`endif
  output logic [GW-1:0] vga_control,
  output logic          step_dn,
  output logic          step_up,
  output logic          rail
);

  localparam int WCW = $clog2(WIN_LEN + 1);
  localparam int CCW = $clog2(CLIP_CNT + 1);
  localparam int HCW = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;

  localparam logic [WCW-1:0] WIN_LAST  = WCW'(WIN_LEN - 1);
  localparam logic [CCW-1:0] CLIP_T    = CCW'(CLIP_CNT);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_WIN > 0) ? HOLD_WIN - 1 : 0);
  localparam logic [DW-2:0]  HI_T      = (DW-1)'(HI_THR);
  localparam logic [DW-2:0]  LO_T      = (DW-1)'(LO_THR);
  localparam logic [GW-1:0]  GMAX      = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] win_cnt, win_nxt;
  logic [CCW-1:0] clip_cnt, clip_nxt;
  logic [DW-2:0]  peak, peak_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic [GW-1:0]  code_nxt;
  logic           dn_nxt, up_nxt, rail_nxt;

  // Offset-binary magnitude: above midscale it is the low bits, below it their complement.
  logic [DW-2:0] mag;
  logic          is_clip;
  logic          want_dn, want_up;

  assign mag     = digital_in[DW-1] ? digital_in[DW-2:0] : ~digital_in[DW-2:0];
  assign is_clip = (mag >= HI_T);
  assign want_dn = (clip_cnt >= CLIP_T);
  assign want_up = !want_dn && (peak < LO_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win_cnt     <= '0;
      clip_cnt    <= '0;
      peak        <= '0;
      hold_cnt    <= '0;
      vga_control <= GW'(GAIN_INIT);
      step_dn     <= 1'b0;
      step_up     <= 1'b0;
      rail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      win_cnt     <= win_nxt;
      clip_cnt    <= clip_nxt;
      peak        <= peak_nxt;
      hold_cnt    <= hold_nxt;
      vga_control <= code_nxt;
      step_dn     <= dn_nxt;
      step_up     <= up_nxt;
      rail        <= rail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt;
    clip_nxt  = clip_cnt;
    peak_nxt  = peak;
    hold_nxt  = hold_cnt;
    code_nxt  = vga_control;
    dn_nxt    = 1'b0;
    up_nxt    = 1'b0;
    rail_nxt  = 1'b0;

`ifdef AGC_MANUAL_EN
    if (manual_en) begin
      state_nxt = IDLE;
      win_nxt   = '0;
      clip_nxt  = '0;
      peak_nxt  = '0;
      hold_nxt  = '0;
      code_nxt  = manual_code;
    end else
`endif
    if (!agc_en) begin
      state_nxt = IDLE;
      win_nxt   = '0;
      clip_nxt  = '0;
      peak_nxt  = '0;
      hold_nxt  = '0;
    end else begin
      case (state)
        IDLE: state_nxt = MEASURE;

        MEASURE: begin
          if (sample_valid) begin
            win_nxt = win_cnt + WCW'(1);
            if (is_clip && (clip_cnt != CLIP_T)) clip_nxt = clip_cnt + CCW'(1);
            if (mag > peak) peak_nxt = mag;
            if (win_cnt == WIN_LAST) state_nxt = DECIDE;
          end
        end

        DECIDE: begin
          // Sample input is ignored here; the window just closed is evaluated.
          win_nxt   = '0;
          clip_nxt  = '0;
          peak_nxt  = '0;
          hold_nxt  = '0;
          state_nxt = MEASURE;
          if (want_dn) begin
            if (vga_control == GMAX) begin
              rail_nxt = 1'b1;
            end else begin
              code_nxt  = vga_control + GW'(1);
              dn_nxt    = 1'b1;
              state_nxt = (HOLD_WIN > 0) ? HOLD : MEASURE;
            end
          end else if (want_up) begin
            if (vga_control == '0) begin
              rail_nxt = 1'b1;
            end else begin
              code_nxt  = vga_control - GW'(1);
              up_nxt    = 1'b1;
              state_nxt = (HOLD_WIN > 0) ? HOLD : MEASURE;
            end
          end
        end

        HOLD: begin
          // Settling time measured in whole windows of valid samples.
          if (sample_valid) begin
            if (win_cnt == WIN_LAST) begin
              win_nxt = '0;
              if (hold_cnt == HOLD_LAST) begin
                hold_nxt  = '0;
                state_nxt = MEASURE;
              end else begin
                hold_nxt = hold_cnt + HCW'(1);
              end
            end else begin
              win_nxt = win_cnt + WCW'(1);
            end
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_level_ctrl.sv
// tb/tb_agc_level_ctrl.sv - randomized self-checking bench for agc_level_ctrl
module tb_agc_level_ctrl;

  localparam int DW = 8, GW = 3, WIN_LEN = 100, HI_THR = 96, LO_THR = 24;
  localparam int CLIP_CNT = 8, HOLD_WIN = 2, GAIN_INIT = 3;
  localparam int MID = 1 << (DW - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] digital_in = '0;
  logic          sample_valid = 1'b0;
  logic          agc_en = 1'b0;
  logic [GW-1:0] vga_control;
  logic          step_dn, step_up, rail;
`ifdef AGC_MANUAL_EN
  logic          manual_en = 1'b0;
  logic [GW-1:0] manual_code = '0;
`endif

  always #5 clk = ~clk;

  agc_level_ctrl #(
    .DW(DW), .GW(GW), .WIN_LEN(WIN_LEN), .HI_THR(HI_THR), .LO_THR(LO_THR),
    .CLIP_CNT(CLIP_CNT), .HOLD_WIN(HOLD_WIN), .GAIN_INIT(GAIN_INIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digital_in(digital_in),
    .sample_valid(sample_valid),
    .agc_en(agc_en),
`ifdef AGC_MANUAL_EN
    .manual_en(manual_en),
    .manual_code(manual_code),
`endif
    .vga_control(vga_control),
    .step_dn(step_dn),
    .step_up(step_up),
    .rail(rail)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a window is a list of magnitudes, hold-off is a sample budget.
  int m_code;
  bit m_active;
  int m_win[$];
  int m_hold;
  bit m_decide;
  bit e_dn, e_up, e_rail;
  int n_dn, n_up, n_rail;

  function automatic int mag_of(input int x);
    return (x >= MID) ? x - MID : MID - 1 - x;
  endfunction

  function automatic int x_of(input int mag);
    return ($urandom_range(1) == 1) ? MID + mag : MID - 1 - mag;
  endfunction

  task automatic model_reset;
    m_code = GAIN_INIT;
    m_active = 0;
    m_win.delete();
    m_hold = 0;
    m_decide = 0;
    e_dn = 0; e_up = 0; e_rail = 0;
  endtask

  task automatic model_edge(input bit en, input bit v, input int x);
    int clips, pk;
    e_dn = 0; e_up = 0; e_rail = 0;
    if (!en) begin
      m_active = 0; m_win.delete(); m_hold = 0; m_decide = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (m_decide) begin
      clips = 0; pk = 0;
      foreach (m_win[i]) begin
        if (m_win[i] >= HI_THR) clips++;
        if (m_win[i] > pk) pk = m_win[i];
      end
      m_decide = 0;
      m_win.delete();
      if (clips >= CLIP_CNT) begin
        if (m_code == (1 << GW) - 1) e_rail = 1;
        else begin m_code++; e_dn = 1; m_hold = HOLD_WIN * WIN_LEN; end
      end else if (pk < LO_THR) begin
        if (m_code == 0) e_rail = 1;
        else begin m_code--; e_up = 1; m_hold = HOLD_WIN * WIN_LEN; end
      end
    end else if (v) begin
      if (m_hold > 0) m_hold--;
      else begin
        m_win.push_back(mag_of(x));
        if (m_win.size() == WIN_LEN) m_decide = 1;
      end
    end
  endtask

  task automatic cyc(input bit v, input int x);
    sample_valid = v;
    digital_in = x[DW-1:0];
    @(posedge clk);
    model_edge(agc_en, v, x);
    #1;
    if (step_dn) n_dn++;
    if (step_up) n_up++;
    if (rail) n_rail++;
  endtask

  task automatic apply_reset;
    agc_en = 0;
    sample_valid = 0;
    #2 rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    n_dn = 0; n_up = 0; n_rail = 0;
  endtask

  task automatic test_reset;
    model_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vga_control, step_dn, step_up, rail} !== {GW'(GAIN_INIT), 3'b000}) begin
      errors++;
      $display("FAIL reset_state got code=%0d pulses=%b%b%b exp code=%0d pulses=000",
               vga_control, step_dn, step_up, rail, GAIN_INIT);
    end
    rst_n = 1;
    agc_en = 1;
    for (int i = 0; i < 152; i++) cyc(1, 255);
    checks++;
    if (vga_control !== GW'(GAIN_INIT + 1)) begin
      errors++;
      $display("FAIL pre_reset_code got %0d exp %0d", vga_control, GAIN_INIT + 1);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({vga_control, step_dn, step_up, rail} !== {GW'(GAIN_INIT), 3'b000}) begin
      errors++;
      $display("FAIL async_reset got code=%0d pulses=%b%b%b exp code=%0d pulses=000",
               vga_control, step_dn, step_up, rail, GAIN_INIT);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    agc_en = 0;
  endtask

  task automatic test_clipping;
    apply_reset();
    agc_en = 1;
    for (int i = 0; i < 1800; i++) begin
      cyc(1, 255);
      checks++;
      if ({vga_control, step_dn, step_up, rail} !== {GW'(m_code), e_dn, e_up, e_rail}) begin
        errors++;
        $display("FAIL clip_cyc%0d got code=%0d dn/up/rail=%b%b%b exp code=%0d dn/up/rail=%b%b%b",
                 i, vga_control, step_dn, step_up, rail, m_code, e_dn, e_up, e_rail);
      end
      if (i == 101) begin
        checks++;
        if ({step_dn, vga_control} !== {1'b1, GW'(4)}) begin
          errors++;
          $display("FAIL clip_first_step got dn=%b code=%0d exp dn=1 code=4", step_dn, vga_control);
        end
      end
    end
    checks++;
    if (vga_control !== GW'(7) || n_dn != 4 || n_rail < 1) begin
      errors++;
      $display("FAIL clip_final got code=%0d dn=%0d rail=%0d exp code=7 dn=4 rail>=1",
               vga_control, n_dn, n_rail);
    end
  endtask

  task automatic test_silence;
    apply_reset();
    agc_en = 1;
    for (int i = 0; i < 1200; i++) begin
      cyc(1, MID);
      checks++;
      if ({vga_control, step_dn, step_up, rail} !== {GW'(m_code), e_dn, e_up, e_rail}) begin
        errors++;
        $display("FAIL silence_cyc%0d got code=%0d dn/up/rail=%b%b%b exp code=%0d dn/up/rail=%b%b%b",
                 i, vga_control, step_dn, step_up, rail, m_code, e_dn, e_up, e_rail);
      end
    end
    checks++;
    if (vga_control !== GW'(0) || n_up != 3 || n_rail < 1) begin
      errors++;
      $display("FAIL silence_final got code=%0d up=%0d rail=%0d exp code=0 up=3 rail>=1",
               vga_control, n_up, n_rail);
    end
  endtask

  task automatic test_nominal;
    int nclip, r, s, x;
    apply_reset();
    agc_en = 1;
    cyc(0, MID);
    for (int w = 0; w < 12; w++) begin
      nclip = (w < 10) ? 0 : ((w == 10) ? CLIP_CNT - 1 : CLIP_CNT);
      r = nclip;
      s = WIN_LEN;
      for (int i = 0; i <= WIN_LEN; i++) begin
        if (i == WIN_LEN) x = 0;
        else if ($urandom_range(s - 1, 0) < r) begin
          x = x_of($urandom_range(MID - 1, HI_THR));
          r--;
        end else x = x_of($urandom_range(HI_THR - 1, LO_THR));
        if (i < WIN_LEN) s--;
        cyc(1, x);
        checks++;
        if ({vga_control, step_dn, step_up, rail} !== {GW'(m_code), e_dn, e_up, e_rail}) begin
          errors++;
          $display("FAIL nominal_w%0d_s%0d got code=%0d dn/up/rail=%b%b%b exp code=%0d dn/up/rail=%b%b%b",
                   w, i, vga_control, step_dn, step_up, rail, m_code, e_dn, e_up, e_rail);
        end
      end
      checks++;
      if ({step_dn, vga_control} !== {(w == 11), GW'((w == 11) ? 4 : 3)}) begin
        errors++;
        $display("FAIL nominal_decide_w%0d got dn=%b code=%0d exp dn=%0d code=%0d",
                 w, step_dn, vga_control, (w == 11), (w == 11) ? 4 : 3);
      end
    end
  endtask

  task automatic test_midop;
    int acc;
    bit v;
    apply_reset();
    agc_en = 1;
    cyc(0, MID);
    acc = 0;
    while (acc < 50) begin
      v = ($urandom_range(3) != 0);
      cyc(v, MID);
      if (v) acc++;
    end
    agc_en = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, MID);
      checks++;
      if ({vga_control, step_dn, step_up, rail} !== {GW'(GAIN_INIT), 3'b000}) begin
        errors++;
        $display("FAIL midop_disabled%0d got code=%0d pulses=%b%b%b exp code=%0d pulses=000",
                 i, vga_control, step_dn, step_up, rail, GAIN_INIT);
      end
    end
    agc_en = 1;
    cyc(1, MID);
    acc = 0;
    while (acc < WIN_LEN - 1) begin
      v = ($urandom_range(3) != 0);
      cyc(v, MID);
      if (v) acc++;
      checks++;
      if ({vga_control, step_dn, step_up, rail} !== {GW'(m_code), e_dn, e_up, e_rail}) begin
        errors++;
        $display("FAIL midop_refill%0d got code=%0d dn/up/rail=%b%b%b exp code=%0d dn/up/rail=%b%b%b",
                 acc, vga_control, step_dn, step_up, rail, m_code, e_dn, e_up, e_rail);
      end
    end
    cyc(1, MID);
    cyc(1, 255);
    checks++;
    if ({step_up, vga_control} !== {1'b1, GW'(GAIN_INIT - 1)}) begin
      errors++;
      $display("FAIL midop_step got up=%b code=%0d exp up=1 code=%0d", step_up, vga_control, GAIN_INIT - 1);
    end
  endtask

  task automatic test_random;
    int mode, x;
    bit v;
    apply_reset();
    agc_en = 1;
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) mode = $urandom_range(2);
      if (agc_en && $urandom_range(399) == 0) agc_en = 0;
      else if (!agc_en && $urandom_range(3) == 0) agc_en = 1;
      v = ($urandom_range(9) < 7);
      case (mode)
        0: x = ($urandom_range(3) == 0) ? x_of($urandom_range(MID - 1, HI_THR))
                                        : x_of($urandom_range(HI_THR - 1, 0));
        1: x = x_of($urandom_range(LO_THR - 1, 0));
        default: x = x_of($urandom_range(HI_THR - 1, LO_THR));
      endcase
      cyc(v, x);
      checks++;
      if ({vga_control, step_dn, step_up, rail} !== {GW'(m_code), e_dn, e_up, e_rail}) begin
        errors++;
        $display("FAIL random_cyc%0d got code=%0d dn/up/rail=%b%b%b exp code=%0d dn/up/rail=%b%b%b",
                 i, vga_control, step_dn, step_up, rail, m_code, e_dn, e_up, e_rail);
      end
    end
  endtask

`ifdef AGC_MANUAL_EN
  task automatic test_manual;
    apply_reset();
    agc_en = 1;
    manual_en = 1;
    manual_code = 6;
    cyc(1, MID);
    checks++;
    if ({vga_control, step_dn, step_up, rail} !== {GW'(6), 3'b000}) begin
      errors++;
      $display("FAIL manual_follow got code=%0d pulses=%b%b%b exp code=6 pulses=000",
               vga_control, step_dn, step_up, rail);
    end
    manual_en = 0;
    n_up = 0;
    cyc(1, MID);
    for (int i = 0; i < WIN_LEN; i++) cyc(1, MID);
    cyc(1, MID);
    checks++;
    if ({step_up, vga_control, n_up} !== {1'b1, GW'(5), 32'sd1}) begin
      errors++;
      $display("FAIL manual_release got up=%b code=%0d ups=%0d exp up=1 code=5 ups=1",
               step_up, vga_control, n_up);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clipping();
    test_silence();
    test_nominal();
    test_midop();
    test_random();
`ifdef AGC_MANUAL_EN
    test_manual();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
